// File: rtl/lut_layer_pipe.sv
// lut_layer_pipe: one registered stage of run-time-loadable truth-table neurons
// with a valid/ready stream and a table write port.
module lut_layer_pipe #(
  parameter int NEURONS  = 4,
  parameter int FANIN    = 6,
  parameter int OUT_BITS = 1,
  parameter int NIDX_W   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NEURONS*FANIN-1:0]     in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NEURONS*OUT_BITS-1:0]  out_data,
  input  logic                         cfg_we,
  input  logic [NIDX_W-1:0]            cfg_neuron,
  input  logic [FANIN-1:0]             cfg_addr,
  input  logic [OUT_BITS-1:0]          cfg_data,
  output logic [15:0]                  lookups
);
  localparam int DEPTH = 1 << FANIN;
  logic [OUT_BITS-1:0] tbl_q [NEURONS][DEPTH];
  logic [OUT_BITS-1:0] tbl_d [NEURONS][DEPTH];
  logic [NEURONS*OUT_BITS-1:0] out_data_q, out_data_d, lut;
  logic out_valid_q, out_valid_d, accept;
  logic [15:0] lookups_q, lookups_d;
  assign in_ready = !out_valid_q || out_ready;
  assign accept = in_valid && in_ready;
  // Lookups read the pre-write table, so a same-cycle write only affects later accepts.
  always_comb begin
    lut = '0;
    for (int n = 0; n < NEURONS; n++)
      lut[n*OUT_BITS +: OUT_BITS] = tbl_q[n][in_data[n*FANIN +: FANIN]];
  end
  always_comb begin
    tbl_d = tbl_q;
    for (int n = 0; n < NEURONS; n++)
      if (cfg_we && int'(cfg_neuron) == n) tbl_d[n][cfg_addr] = cfg_data;
  end
  always_comb begin
    out_valid_d = accept || (out_valid_q && !out_ready);
    out_data_d  = accept ? lut : out_data_q;
    lookups_d   = lookups_q + 16'(accept);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      lookups_q   <= '0;
    end else begin
      tbl_q       <= tbl_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      lookups_q   <= lookups_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign lookups   = lookups_q;
endmodule
